// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 4-digit common-anode display with minimum hold time,
// latched BCD value of the owner, and a free-running digit scan.
module seg_display_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SCAN_DIV = 500000,
    parameter int unsigned HOLD_MIN = 100000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [16*NUM_REQ-1:0]   data_flat,
    output logic [NUM_REQ-1:0]      grant,
    output logic                    busy,
    output logic [6:0]              led_out,
    output logic [3:0]              A_Act
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_MIN);
    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MIN - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t               r_state, w_state;
    logic [IDX_W-1:0]     r_rr_ptr, w_rr_ptr;
    logic [IDX_W-1:0]     r_owner, w_owner;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic                 r_busy;
    logic [HOLD_W-1:0]    r_hold, w_hold;
    logic [SCAN_W-1:0]    r_scan, w_scan;
    logic [1:0]           r_level, w_level;
    logic [15:0]          r_disp, w_disp;
    logic [6:0]           r_led, w_led;
    logic [3:0]           r_an, w_an;
    logic                 w_found;
    logic [IDX_W-1:0]     w_win;
    logic [3:0]           w_nib;
    logic [15:0]          w_data [NUM_REQ];

    // Active-low {g,f,e,d,c,b,a}; anything outside 0-9 renders as a dash.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_data[i] = data_flat[16*i +: 16];
        end
    end

    // Next-state: arbitration, hold timing and display latch.
    always_comb begin
        int unsigned      v_base;
        int unsigned      v_cnt;
        logic [IDX_W-1:0] v_idx;

        w_state  = r_state;
        w_rr_ptr = r_rr_ptr;
        w_owner  = r_owner;
        w_grant  = r_grant;
        w_hold   = r_hold;
        w_disp   = r_disp;
        w_found  = 1'b0;
        w_win    = r_owner;
        v_idx    = '0;

        // From IDLE search all from rr_ptr; at expiry search only the others.
        if (r_state == IDLE) begin
            v_base = 32'(r_rr_ptr);
            v_cnt  = NUM_REQ;
        end else begin
            v_base = (32'(r_owner) + 1) % NUM_REQ;
            v_cnt  = NUM_REQ - 1;
        end

        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = IDX_W'((v_base + k) % NUM_REQ);
            if (!w_found && (k < v_cnt) && req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state = OWN;
                    w_owner = w_win;
                    w_grant = NUM_REQ'(1) << w_win;
                    w_hold  = '0;
                    w_disp  = w_data[w_win];
                end
            end
            OWN: begin
                if (r_hold != HOLD_LAST) begin
                    w_hold = r_hold + HOLD_W'(1);
                    if (req[r_owner]) w_disp = w_data[r_owner];
                end else if (w_found) begin
                    w_owner = w_win;
                    w_grant = NUM_REQ'(1) << w_win;
                    w_hold  = '0;
                    w_disp  = w_data[w_win];
                end else if (req[r_owner]) begin
                    w_disp = w_data[r_owner];
                end else begin
                    w_state  = IDLE;
                    w_grant  = '0;
                    w_rr_ptr = IDX_W'(v_base);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // Digit scan runs in every state; the new owner picks up at the current level.
    always_comb begin
        w_scan  = r_scan + SCAN_W'(1);
        w_level = r_level;
        if (r_scan == SCAN_LAST) begin
            w_scan  = '0;
            w_level = r_level + 2'd1;
        end

        case (w_level)
            2'd0:    begin w_an = 4'b0111; w_nib = w_disp[15:12]; end
            2'd1:    begin w_an = 4'b1011; w_nib = w_disp[11:8];  end
            2'd2:    begin w_an = 4'b1101; w_nib = w_disp[7:4];   end
            default: begin w_an = 4'b1110; w_nib = w_disp[3:0];   end
        endcase
        w_led = seg7(w_nib);

        if (w_state == IDLE) begin
            w_an  = 4'b1111;
            w_led = 7'b1111111;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_busy   <= 1'b0;
            r_hold   <= '0;
            r_scan   <= '0;
            r_level  <= 2'd0;
            r_disp   <= 16'h0000;
            r_led    <= 7'b1111111;
            r_an     <= 4'b1111;
        end else begin
            r_state  <= w_state;
            r_rr_ptr <= w_rr_ptr;
            r_owner  <= w_owner;
            r_grant  <= w_grant;
            r_busy   <= (w_state == OWN);
            r_hold   <= w_hold;
            r_scan   <= w_scan;
            r_level  <= w_level;
            r_disp   <= w_disp;
            r_led    <= w_led;
            r_an     <= w_an;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign led_out = r_led;
    assign A_Act   = r_an;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_seg_display_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned HOLD_MIN = 16;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SD   = 7'b0111111;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req;
    logic [16*NUM_REQ-1:0]  data_flat;
    logic [NUM_REQ-1:0]     grant;
    logic                   busy;
    logic [6:0]             led_out;
    logic [3:0]             A_Act;

    typedef struct {
        int         cyc;
        bit         chk_g;
        bit         chk_d;
        logic [3:0] g;
        logic [3:0] an;
        logic [6:0] led;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   t0;
    int   t1;

    seg_display_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .SCAN_DIV (SCAN_DIV),
        .HOLD_MIN (HOLD_MIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_flat (data_flat),
        .grant     (grant),
        .busy      (busy),
        .led_out   (led_out),
        .A_Act     (A_Act)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has come.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                n_vec++;
                if ((q[i].chk_g && (grant !== q[i].g || busy !== (|q[i].g))) ||
                    (q[i].chk_d && (A_Act !== q[i].an || led_out !== q[i].led))) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: grant=%b busy=%b A_Act=%b led=%b, required grant=%b A_Act=%b led=%b (chk_g=%0b chk_d=%0b)",
                             q[i].nm, cyc, grant, busy, A_Act, led_out,
                             q[i].g, q[i].an, q[i].led, q[i].chk_g, q[i].chk_d);
                end
                q.delete(i);
            end
        end
    end

    task automatic push(input int at, input bit cg, input bit cd, input logic [3:0] g,
                        input logic [3:0] an, input logic [6:0] led, input string nm);
        exp_t e;
        e.cyc = at; e.chk_g = cg; e.chk_d = cd; e.g = g; e.an = an; e.led = led; e.nm = nm;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_data(input int idx, input logic [15:0] v);
        data_flat[16*idx +: 16] = v;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        data_flat = '0;
        push(2, 1, 1, 4'b0000, 4'b1111, SOFF, "reset_state");
        wait_cyc(3);

        // Single requester: grant latency, scan order, live update, dash.
        rst_n = 1'b1;
        t0    = cyc;
        req   = 4'b0001;
        set_data(0, 16'h9625);
        push(t0 + 1,   1, 1, 4'b0001, 4'b0111, S9, "grant0_digit3");
        push(t0 + 4,   0, 1, 4'b0000, 4'b1011, S6, "scan_digit2");
        push(t0 + 8,   0, 1, 4'b0000, 4'b1101, S2, "scan_digit1");
        push(t0 + 12,  0, 1, 4'b0000, 4'b1110, S5, "scan_digit0");
        push(t0 + 16,  1, 1, 4'b0001, 4'b0111, S9, "scan_wrap");
        push(t0 + 31,  0, 1, 4'b0000, 4'b1110, S4, "live_9224");
        push(t0 + 41,  0, 1, 4'b0000, 4'b1101, S5, "live_9756");
        push(t0 + 51,  0, 1, 4'b0000, 4'b0111, SD, "nonbcd_dash");
        push(t0 + 100, 1, 1, 4'b0001, 4'b1011, S7, "sole_owner_100");
        wait_cyc(t0 + 30); set_data(0, 16'h9224);
        wait_cyc(t0 + 40); set_data(0, 16'h9756);
        wait_cyc(t0 + 50); set_data(0, 16'hB756);

        // Asynchronous reset between edges while owning.
        wait_cyc(t0 + 101);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        n_vec++;
        if (grant !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_grant: grant=%b, required 0000", grant);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_busy: busy=%b, required 0", busy);
        end
        n_vec++;
        if (A_Act !== 4'b1111) begin
            n_err++;
            $display("FAIL async_reset_an: A_Act=%b, required 1111", A_Act);
        end
        n_vec++;
        if (led_out !== SOFF) begin
            n_err++;
            $display("FAIL async_reset_led: led_out=%b, required 1111111", led_out);
        end
        push(cyc, 1, 1, 4'b0000, 4'b1111, SOFF, "async_reset");
        wait_cyc(t0 + 104);

        // Round-robin rotation, hold time, owner drop, idle and rr_ptr.
        rst_n = 1'b1;
        t1    = cyc;
        req   = 4'b1111;
        set_data(0, 16'h1234);
        set_data(1, 16'h5678);
        set_data(2, 16'h0000);
        set_data(3, 16'h0000);
        push(t1 + 1,   1, 0, 4'b0001, 4'b0000, SOFF, "rr_first0");
        push(t1 + 16,  1, 0, 4'b0001, 4'b0000, SOFF, "rr_hold_end0");
        push(t1 + 17,  1, 0, 4'b0010, 4'b0000, SOFF, "rr_to1");
        push(t1 + 32,  1, 0, 4'b0010, 4'b0000, SOFF, "rr_hold_end1");
        push(t1 + 33,  1, 0, 4'b0100, 4'b0000, SOFF, "rr_to2");
        push(t1 + 49,  1, 0, 4'b1000, 4'b0000, SOFF, "rr_to3");
        push(t1 + 65,  1, 0, 4'b0001, 4'b0000, SOFF, "rr_wrap0");
        push(t1 + 70,  1, 1, 4'b0001, 4'b1011, S3, "drop_frozen");
        push(t1 + 80,  1, 0, 4'b0001, 4'b0000, SOFF, "drop_still_held");
        push(t1 + 81,  1, 1, 4'b0010, 4'b0111, S5, "drop_handover1");
        push(t1 + 98,  1, 1, 4'b0100, 4'b0111, S0, "owner2_value");
        push(t1 + 112, 1, 0, 4'b0100, 4'b0000, SOFF, "owner2_held");
        push(t1 + 113, 1, 1, 4'b0000, 4'b1111, SOFF, "idle_after_drop");
        push(t1 + 117, 1, 1, 4'b1000, 4'b1011, S0, "rr_ptr3_first");
        wait_cyc(t1 + 66); set_data(0, 16'h4321);
        wait_cyc(t1 + 67); req = 4'b0010; set_data(0, 16'h9999);
        wait_cyc(t1 + 81); req = 4'b0100;
        wait_cyc(t1 + 100); req = 4'b0000;
        wait_cyc(t1 + 116); req = 4'b1111;
        wait_cyc(t1 + 120);

        n_vec++;
        if (grant !== 4'b1000) begin
            n_err++;
            $display("FAIL rr_ptr3_held: grant=%b, required 1000", grant);
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rr_ptr3_busy: busy=%b, required 1", busy);
        end

        while (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: expectation for cyc %0d never checked (now %0d)", q[0].nm, q[0].cyc, cyc);
            void'(q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
